jtframe_shadow_load: RTL

- Restores an SDRAM bank-0 region from an NVRAM upload (hps ioctl download stream): the reverse of the shadow dump path.
- Accepts byte writes on the ioctl interface and packs them into 16-bit words with byte masks.
- Buffers words in a small synchronous FIFO.
- Issues bank-0 SDRAM write requests at START + byte offset, using a request/ack handshake.

---
 rtl/jtframe_shadow_pkg.sv | 20 ++
 rtl/jtframe_shadow_fifo.sv | 60 ++++++
 rtl/jtframe_shadow_load.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/jtframe_shadow_pkg.sv
// Shared types and constants for the NVRAM-to-SDRAM shadow load path.
package jtframe_shadow_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // SDRAM write masks are active low: bit1 = upper byte, bit0 = lower byte
    localparam logic [1:0] MASK_WORD = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    // FIFO entry is {word index, data, mask}
    function automatic int unsigned entry_w(input int unsigned lw);
        return lw + 18;
    endfunction

endpackage

// File: rtl/jtframe_shadow_fifo.sv
// Small synchronous FIFO with two ordered pushes (push0 before push1) and one pop.
module jtframe_shadow_fifo #(
    parameter int unsigned FW = 2,
    parameter int unsigned W  = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push0,
    input  logic [W-1:0] din0,
    input  logic         push1,
    input  logic [W-1:0] din1,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         drop0,
    output logic         drop1
);

    localparam int unsigned DEPTH = 2 ** FW;

    logic [W-1:0]  mem [DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [FW:0]   cnt;
    logic          pop_ok, acc0, acc1;
    logic [FW+1:0] free0, free1;

    assign empty = (cnt == '0);
    assign full  = (cnt == (FW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // A pop in the same cycle frees a slot for the pushes
    always_comb begin
        pop_ok = pop & ~empty;
        free0  = (FW+2)'(DEPTH) - {1'b0, cnt} + (FW+2)'(pop_ok);
        acc0   = push0 && (free0 != '0);
        free1  = free0 - (FW+2)'(acc0);
        acc1   = push1 && (free1 != '0);
        drop0  = push0 & ~acc0;
        drop1  = push1 & ~acc1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + FW'(acc0) + FW'(acc1);
            rd_ptr <= rd_ptr + FW'(pop_ok);
            cnt    <= cnt + (FW+1)'(acc0) + (FW+1)'(acc1) - (FW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (acc0) mem[wr_ptr] <= din0;
        if (acc1) mem[wr_ptr + FW'(acc0)] <= din1;
    end

endmodule

// File: rtl/jtframe_shadow_load.sv
// Restores an SDRAM bank-0 region from an ioctl NVRAM upload, packing bytes into masked words.
// Optional JTFRAME_SHADOW_CHKSUM_EN adds a 16-bit running sum of accepted bytes.
module jtframe_shadow_load
    import jtframe_shadow_pkg::*;
#(
    parameter int unsigned   AW    = 22,
    parameter logic [AW-1:0] START = AW'(22'h10_0000),
    parameter int unsigned   LW    = 15,
    parameter int unsigned   FW    = 2
) (
    input  logic          rst,
    input  logic          clk_rom,
    input  logic          ioctl_ram,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [AW-1:0] ba0_addr,
    output logic          ba0_wr,
    output logic [15:0]   ba0_din,
    output logic [1:0]    ba0_din_m,
    input  logic          ba0_ack,
    output logic          busy,
    output logic          overflow
`ifdef JTFRAME_SHADOW_CHKSUM_EN
    ,
    output logic [15:0]   chksum
`endif
);

    localparam int unsigned EW = entry_w(LW);

    logic          pend_v_q, pend_v_d;
    logic [LW-1:0] pend_idx_q, pend_idx_d;
    logic [7:0]    pend_b_q, pend_b_d;
    logic          ram_q, ram_rise, ram_fall;
    logic          accept;
    logic [LW-1:0] wr_idx;

    logic          push0, push1, pop;
    logic [EW-1:0] din0, din1, fifo_dout;
    logic          fifo_empty, fifo_full, drop0, drop1;

    state_t        state_q, state_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   din_q, din_d;
    logic [1:0]    m_q, m_d;
    logic          ovf_q;

    assign accept   = ioctl_wr & ioctl_ram & (ioctl_addr[AW-1:LW+1] == '0);
    assign wr_idx   = ioctl_addr[LW:1];
    assign ram_rise = ioctl_ram & ~ram_q;
    assign ram_fall = ~ioctl_ram & ram_q;

    // Byte packer: an even byte waits for its odd partner; anything unmatched goes out alone
    always_comb begin
        push0      = 1'b0;
        push1      = 1'b0;
        din0       = {pend_idx_q, 8'h00, pend_b_q, MASK_LO};
        din1       = {wr_idx, ioctl_dout, 8'h00, MASK_HI};
        pend_v_d   = pend_v_q;
        pend_idx_d = pend_idx_q;
        pend_b_d   = pend_b_q;
        if (accept) begin
            if (!ioctl_addr[0]) begin
                push0      = pend_v_q;
                pend_v_d   = 1'b1;
                pend_idx_d = wr_idx;
                pend_b_d   = ioctl_dout;
            end else if (pend_v_q && pend_idx_q == wr_idx) begin
                push0    = 1'b1;
                din0     = {wr_idx, ioctl_dout, pend_b_q, MASK_WORD};
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                push0    = 1'b1;
                push1    = 1'b1;
                pend_v_d = 1'b0;
            end else begin
                push0 = 1'b1;
                din0  = {wr_idx, ioctl_dout, 8'h00, MASK_HI};
            end
        end else if (ram_fall && pend_v_q) begin
            push0    = 1'b1;
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            pend_v_q   <= 1'b0;
            pend_idx_q <= '0;
            pend_b_q   <= '0;
            ram_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            pend_v_q   <= pend_v_d;
            pend_idx_q <= pend_idx_d;
            pend_b_q   <= pend_b_d;
            ram_q      <= ioctl_ram;
            if (drop0 || drop1) ovf_q <= 1'b1;
            else if (ram_rise)  ovf_q <= 1'b0;
        end
    end

    jtframe_shadow_fifo #(
        .FW (FW),
        .W  (EW)
    ) u_fifo (
        .clk   (clk_rom),
        .rst   (rst),
        .push0 (push0),
        .din0  (din0),
        .push1 (push1),
        .din1  (din1),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .drop0 (drop0),
        .drop1 (drop1)
    );

    // The head is popped as it moves into the request registers, so REQ holds one extra word
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        m_d     = m_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    addr_d  = START + AW'({fifo_dout[EW-1:18], 1'b0});
                    din_d   = fifo_dout[17:2];
                    m_d     = fifo_dout[1:0];
                    pop     = 1'b1;
                    wr_d    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ba0_ack) begin
                    wr_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            m_q     <= MASK_NONE;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            m_q     <= m_d;
        end
    end

    always_ff @(posedge clk_rom) begin
        if (!rst) assert (!(fifo_full && fifo_empty));
    end

    assign ba0_wr    = wr_q;
    assign ba0_addr  = addr_q;
    assign ba0_din   = din_q;
    assign ba0_din_m = m_q;
    assign overflow  = ovf_q;
    assign busy      = pend_v_q | ~fifo_empty | (state_q != ST_IDLE);

`ifdef JTFRAME_SHADOW_CHKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk_rom) begin
        if (rst)           sum_q <= '0;
        else if (ram_rise) sum_q <= accept ? {8'h00, ioctl_dout} : 16'h0000;
        else if (accept)   sum_q <= sum_q + {8'h00, ioctl_dout};
    end

    assign chksum = sum_q;
`endif

endmodule
